// File: rtl/radix4_pkg.sv
// radix4_pkg: shared widths and Booth digit encoding for the radix-4 multiplier.
package radix4_pkg;
    localparam int OP_W   = 32;
    localparam int PROD_W = 64;
    localparam int ACC_W  = 34;
    localparam int CNT_W  = 5;
    localparam int N_ITER = 16;
    typedef enum logic [2:0] {ZERO, PM, P2M, M2M, MM} booth_digit_t;
endpackage

// File: rtl/radix4_if.sv
// radix4_if: operand, control and product bundle for the radix4 multiplier.
interface radix4_if;
    import radix4_pkg::*;
    logic [OP_W-1:0]   inputM;
    logic [OP_W-1:0]   inputQ;
    logic [CNT_W-1:0]  cnt_start;
    logic [CNT_W-1:0]  cnt_step;
    logic [PROD_W-1:0] out;
    modport master (output inputM, inputQ, cnt_start, cnt_step, input out);
    modport slave (input inputM, inputQ, cnt_start, cnt_step, output out);
endinterface

// File: rtl/radix4_booth_recoder.sv
// booth_recoder: maps a {q+1, q, q-1} triplet to its radix-4 Booth digit.
module booth_recoder
    import radix4_pkg::*;
(
    input  logic [2:0]   triplet,
    output booth_digit_t digit
);
    always_comb begin
        digit = (triplet == 3'b000 || triplet == 3'b111) ? ZERO :
                (triplet == 3'b011) ? P2M :
                (triplet == 3'b100) ? M2M :
                triplet[2] ? MM : PM;
    end
endmodule

// File: rtl/radix4.sv
// radix4: sequential 32x32 signed radix-4 Booth multiplier, two multiplier bits per clock.
module radix4
    import radix4_pkg::*;
(
    input logic     clk,
    input logic     reset,
    radix4_if.slave bus
);
    localparam int P_W = ACC_W + OP_W + 1;
    logic [OP_W-1:0]  m;
    logic [P_W-1:0]   p;
    logic [CNT_W-1:0] cnt;
    logic             done;
    booth_digit_t     digit;
    logic [ACC_W-1:0] m_ext, m2, addend, a_new;
    logic [P_W-1:0]   shifted;

    booth_recoder u_rec (.triplet(p[2:0]), .digit(digit));

    // 34-bit accumulator keeps +/-2M in range even for the most-negative multiplicand
    assign m_ext   = {{(ACC_W-OP_W){m[OP_W-1]}}, m};
    assign m2      = m_ext << 1;
    assign addend  = digit == PM  ? m_ext :
                     digit == P2M ? m2 :
                     digit == MM  ? ~m_ext + ACC_W'(1) :
                     digit == M2M ? ~m2 + ACC_W'(1) : '0;
    assign a_new   = p[P_W-1:OP_W+1] + addend;
    assign shifted = {{2{a_new[ACC_W-1]}}, a_new, p[OP_W:2]};

    always_ff @(posedge clk) begin
        if (reset) begin
            m       <= bus.inputM;
            p       <= {{ACC_W{1'b0}}, bus.inputQ, 1'b0};
            cnt     <= bus.cnt_start;
            done    <= 1'b0;
            bus.out <= '0;
        end else if (cnt < CNT_W'(N_ITER)) begin
            p   <= shifted;
            cnt <= cnt + bus.cnt_step;
        end else if (!done) begin
            bus.out <= p[PROD_W:1];
            done    <= 1'b1;
        end
    end
endmodule

// File: tb/tb_radix4.sv
// tb_radix4: directed checks of the radix4 Booth multiplier with hand-computed products.
module tb_radix4;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int tests = 0;
    int failed = 0;

    radix4_if bus();
    radix4 dut (.clk(clk), .reset(reset), .bus(bus.slave));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Loads operands under a 3-cycle reset, scrambles inputs after release, reads after 40 cycles.
    task automatic run(input logic [31:0] mm, input logic [31:0] qq, input logic [4:0] cs,
                       input logic [4:0] st, input logic [63:0] exp, input string tag);
        @(negedge clk);
        reset = 1'b1;
        bus.inputM = mm;
        bus.inputQ = qq;
        bus.cnt_start = cs;
        bus.cnt_step = st;
        @(posedge clk);
        #1 chk({tag, "_rst"}, bus.out, 64'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        bus.inputM = ~mm;
        bus.inputQ = 32'h1234_5678;
        repeat (40) @(posedge clk);
        #1 chk(tag, bus.out, exp);
    endtask

    initial begin
        bus.inputM = '0;
        bus.inputQ = '0;
        bus.cnt_start = '0;
        bus.cnt_step = 5'd1;
        run(32'd7, 32'd2, 5'd0, 5'd1, 64'd14, "7x2");
        run(-32'sd2, -32'sd5, 5'd0, 5'd1, 64'd10, "n2xn5");
        run(-32'sd2, -32'sd3, 5'd0, 5'd1, 64'd6, "n2xn3");
        run(32'd3, 32'd3, 5'd0, 5'd1, 64'd9, "3x3");
        run(-32'sd5, 32'd2, 5'd0, 5'd1, 64'hFFFF_FFFF_FFFF_FFF6, "n5x2");
        run(32'd2, -32'sd5, 5'd0, 5'd1, 64'hFFFF_FFFF_FFFF_FFF6, "2xn5");
        run(32'hF000_00F5, 32'd0, 5'd0, 5'd1, 64'd0, "bigx0");
        run(32'd1, 32'h0000_00CF, 5'd0, 5'd1, 64'd207, "1xCF");
        run(32'hFFFF_FF01, 32'h0000_0139, 5'd0, 5'd1, 64'hFFFF_FFFF_FFFE_C839, "n255x313");
        run(32'h8000_0000, 32'h8000_0000, 5'd0, 5'd1, 64'h4000_0000_0000_0000, "minxmin");
        // only the low 16 multiplier bits get retired: partial 14 lands at weight 2^16
        run(32'd7, 32'd2, 5'd8, 5'd1, 64'h0000_0000_000E_0000, "start8");
        run(32'd7, 32'd2, 5'd0, 5'd2, 64'h0000_0000_000E_0000, "step2");
        run(32'd7, 32'd2, 5'd0, 5'd0, 64'd0, "step0");
        @(negedge clk);
        reset = 1'b1;
        bus.inputM = 32'd7;
        bus.inputQ = 32'd2;
        bus.cnt_start = 5'd0;
        bus.cnt_step = 5'd1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        bus.inputM = 32'd3;
        bus.inputQ = 32'd3;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1 chk("abort_rst", bus.out, 64'h0);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk);
            #1 chk($sformatf("hold0_c%0d", i), bus.out, 64'h0);
        end
        for (int i = 17; i <= 20; i++) begin
            @(posedge clk);
            #1 chk($sformatf("final_c%0d", i), bus.out, 64'd9);
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
